// File: rtl/clb_cfg_loader.sv
// CLB configuration chain loader: serialises per-CLB words onto prog_in/prog_en
// and optionally replays the bitstream against prog_out to verify the chain.
module clb_cfg_loader #(
  parameter  int CFG_BITS = 17,
  parameter  int NUM_CLB  = 4,
  localparam int L        = CFG_BITS * NUM_CLB,
  localparam int CW       = $clog2(L + 1)
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic                start,
  input  logic                verify_en,
  input  logic [CFG_BITS-1:0] word_in,
  input  logic                word_valid,
  output logic                word_ready,
  output logic                prog_en,
  output logic                prog_in,
  input  logic                prog_out,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [CW-1:0]       mismatch_cnt
);

  localparam int NW = $clog2(NUM_CLB + 1);
  localparam int BW = $clog2(CFG_BITS);
  localparam int PW = $clog2(L);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_VERIFY, S_FINISH
  } state_t;

  state_t r_state, w_next;

  logic                r_verify;
  logic                r_full;
  logic [BW-1:0]       r_bit;
  logic [NW-1:0]       r_nacc;
  logic [CFG_BITS-1:0] r_shift;
  logic [L-1:0]        r_buf;
  logic [PW-1:0]       r_vptr;
  logic                r_err;
  logic [CW-1:0]       r_cnt;
  logic                r_en;
  logic                r_din;

  logic          w_last_bit;
  logic          w_room;
  logic          w_ready;
  logic          w_accept;
  logic          w_load_end;
  logic          w_vlast;
  logic [PW-1:0] w_base;

  assign w_last_bit = r_full && (r_bit == BW'(CFG_BITS - 1));
  assign w_room     = r_nacc < NW'(NUM_CLB);
  assign w_load_end = (r_state == S_LOAD) && w_last_bit && !w_room;
  assign w_vlast    = r_vptr == PW'(L - 1);
  assign w_base     = PW'(r_nacc) * PW'(CFG_BITS);
  assign w_accept   = w_ready && word_valid;

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD: begin
        // Refill on the last bit keeps back-to-back words bubble-free
        w_ready = w_room && (!r_full || w_last_bit);
        if (w_load_end) w_next = r_verify ? S_VERIFY : S_FINISH;
      end
      S_VERIFY: if (w_vlast) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_verify <= 1'b0;
      r_full   <= 1'b0;
      r_bit    <= '0;
      r_nacc   <= '0;
      r_shift  <= '0;
      r_buf    <= '0;
      r_vptr   <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_en     <= 1'b0;
      r_din    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_en  <= 1'b0;
          r_din <= 1'b0;
          if (start) begin
            r_verify <= verify_en;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_nacc   <= '0;
            r_full   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_shift                   <= word_in;
            r_buf[w_base +: CFG_BITS] <= word_in;
            r_nacc                    <= r_nacc + NW'(1);
            r_bit                     <= '0;
            r_full                    <= 1'b1;
            r_en                      <= 1'b1;
            r_din                     <= word_in[0];
          end else if (w_load_end && r_verify) begin
            r_full <= 1'b0;
            r_vptr <= '0;
            r_en   <= 1'b1;
            r_din  <= r_buf[0];
          end else if (w_last_bit) begin
            r_full <= 1'b0;
            r_en   <= 1'b0;
            r_din  <= 1'b0;
          end else if (r_full) begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + BW'(1);
            r_din   <= r_shift[1];
          end
        end
        S_VERIFY: begin
          // Rotating the buffer leaves it intact after L replay cycles
          r_buf  <= {r_buf[0], r_buf[L-1:1]};
          r_din  <= r_buf[1];
          r_vptr <= r_vptr + PW'(1);
          if (prog_out != r_din) begin
            r_err <= 1'b1;
            if (r_cnt != CW'(L)) r_cnt <= r_cnt + CW'(1);
          end
          if (w_vlast) begin
            r_en  <= 1'b0;
            r_din <= 1'b0;
          end
        end
        S_FINISH: begin
          r_en  <= 1'b0;
          r_din <= 1'b0;
        end
        default: begin
          r_en  <= 1'b0;
          r_din <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready   = w_ready;
  assign prog_en      = r_en;
  assign prog_in      = r_din;
  assign busy         = (r_state == S_LOAD) || (r_state == S_VERIFY);
  assign done         = r_state == S_FINISH;
  assign error        = r_err;
  assign mismatch_cnt = r_cnt;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed bench for clb_cfg_loader with a behavioural 68-stage chain.
module tb_clb_cfg_loader;

  localparam int CB = 17;
  localparam int NC = 4;
  localparam int L  = CB * NC;
  localparam int CW = $clog2(L + 1);

  logic          clk = 1'b0;
  logic          prog_rst_n;
  logic          start, verify_en, word_valid;
  logic [CB-1:0] word_in;
  logic          word_ready, prog_en, prog_in, prog_out;
  logic          busy, done, error;
  logic [CW-1:0] mismatch_cnt;

  clb_cfg_loader #(.CFG_BITS(CB), .NUM_CLB(NC)) dut (
    .prog_clk    (clk),
    .prog_rst_n  (prog_rst_n),
    .start       (start),
    .verify_en   (verify_en),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .prog_en     (prog_en),
    .prog_in     (prog_in),
    .prog_out    (prog_out),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  logic [L-1:0]   chain;
  logic [2*L-1:0] seqv;
  logic           mon_clr, flip;
  int             en_cnt, en_n, busy_n, gap_n, dn_n, hs_n;
  int             n_cmp, n_bad;
  logic [CB-1:0]  words [NC];

  always @(posedge clk) begin
    if (prog_en) chain <= {chain[L-2:0], prog_in};
    if (mon_clr)      en_cnt <= 0;
    else if (prog_en) en_cnt <= en_cnt + 1;
  end

  assign prog_out = chain[L-1] ^
    (flip && (en_cnt == L + 5 || en_cnt == L + 40));

  always @(negedge clk) begin
    if (mon_clr) begin
      en_n <= 0; busy_n <= 0; gap_n <= 0;
      dn_n <= 0; hs_n <= 0;
    end else begin
      if (prog_en) begin
        if (en_n < 2 * L) seqv[en_n] <= prog_in;
        en_n <= en_n + 1;
      end
      if (busy) busy_n <= busy_n + 1;
      if (busy && !prog_en) gap_n <= gap_n + 1;
      if (done) dn_n <= dn_n + 1;
      if (word_valid && word_ready) hs_n <= hs_n + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [L-1:0] exp_chain();
    logic [L-1:0] e;
    e = '0;
    for (int n = 0; n < NC; n++)
      for (int b = 0; b < CB; b++)
        e[L-1-(n*CB+b)] = words[n][b];
    return e;
  endfunction

  function automatic logic [127:0] outs();
    return 128'({word_ready, prog_en, prog_in, busy,
                 done, error, mismatch_cnt});
  endfunction

  task automatic run(input bit ver, input int stall_at,
                     input int stall_n, input int abort_at,
                     input int p1, input int p2,
                     output int lat);
    int idx, sl;
    bit fin;
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr    = 1'b0;
    start      = 1'b1;
    verify_en  = ver;
    word_valid = 1'b1;
    word_in    = words[0];
    idx = 0; sl = stall_n; lat = 0; fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      lat++;
      start     = (lat == p1 || lat == p2);
      verify_en = 1'b0;
      if (lat == abort_at) begin
        prog_rst_n = 1'b0;
        #1;
        chk("reset_mid_load", outs(), '0);
        fin = 1'b1;
      end else if (done) begin
        fin = 1'b1;
      end else begin
        word_valid = (idx < NC) && !(idx == stall_at && sl > 0);
        if (idx < NC) word_in = words[idx];
        #1;
        if (word_ready) begin
          if (word_valid) idx++;
          else if (idx == stall_at && sl > 0) sl--;
        end
      end
    end
    if (!fin) chk("timeout", 0, 1);
    start      = 1'b0;
    word_valid = 1'b0;
    @(negedge clk);
  endtask

  int lat;

  initial begin
    n_cmp = 0; n_bad = 0;
    prog_rst_n = 1'b0; start = 1'b0; verify_en = 1'b0;
    word_valid = 1'b0; word_in = '0; flip = 1'b0;
    mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), '0);
    prog_rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs(), '0);

    words[0] = 17'b11101110111011100;
    words[1] = 17'h0F0F1;
    words[2] = 17'h15A5A;
    words[3] = 17'h1C003;
    run(1'b0, -1, 0, -1, -1, -1, lat);
    chk("A_lat", lat, L + 2);
    chk("A_en", en_n, L);
    chk("A_gap", gap_n, 1);
    chk("A_busy", busy_n, L + 1);
    chk("A_hs", hs_n, 4);
    chk("A_done", dn_n, 1);
    chk("A_seq0", seqv[16:0], 17'h1DDDC);
    chk("A_chain", chain, exp_chain());
    chk("A_err", error, 0);

    words[0] = 17'h12345;
    words[1] = 17'h0ABCD;
    words[2] = 17'h1FFFF;
    words[3] = 17'h00001;
    run(1'b0, 2, 3, -1, -1, -1, lat);
    chk("B_lat", lat, L + 5);
    chk("B_en", en_n, L);
    chk("B_gap", gap_n, 4);
    chk("B_hs", hs_n, 4);
    chk("B_chain", chain, exp_chain());

    run(1'b1, -1, 0, -1, -1, -1, lat);
    chk("C_lat", lat, 2 * L + 2);
    chk("C_en", en_n, 2 * L);
    chk("C_gap", gap_n, 1);
    chk("C_err", error, 0);
    chk("C_cnt", mismatch_cnt, 0);
    chk("C_chain", chain, exp_chain());

    flip = 1'b1;
    run(1'b1, -1, 0, -1, 10, 120, lat);
    flip = 1'b0;
    chk("D_lat", lat, 2 * L + 2);
    chk("D_en", en_n, 2 * L);
    chk("D_hs", hs_n, 4);
    chk("D_done", dn_n, 1);
    chk("D_err", error, 1);
    chk("D_cnt", mismatch_cnt, 2);
    chk("D_chain", chain, exp_chain());

    run(1'b0, -1, 0, 41, -1, -1, lat);
    prog_rst_n = 1'b1;
    @(negedge clk);
    chk("E_idle", outs(), '0);

    words[0] = 17'h00F00;
    words[1] = 17'h10101;
    words[2] = 17'h0AAAA;
    words[3] = 17'h15555;
    run(1'b0, -1, 0, -1, -1, -1, lat);
    chk("F_lat", lat, L + 2);
    chk("F_en", en_n, L);
    chk("F_hs", hs_n, 4);
    chk("F_chain", chain, exp_chain());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
